// File: rtl/lsu_pkg.sv
// Shared load/store sequencer types: FSM states, access-size encodings and the
// latched request payload.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} lsu_state_t;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam logic [1:0] MEM_D = 2'b11;

  localparam int unsigned CNT_W = 16;

  // Request fields that must survive past the IDLE acceptance cycle
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata_hi;
  } lsu_req_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] addr);
    logic ok;
    case (size)
      MEM_B:   ok = 1'b1;
      MEM_H:   ok = (addr[0] == 1'b0);
      MEM_W:   ok = (addr[1:0] == 2'b00);
      default: ok = (addr == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_bus_sequencer_if.sv
// 32-bit request/acknowledge data-memory bus between the sequencer and the slave.
interface lsu_bus_sequencer_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [31:0]       bus_rdata;
  logic              bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata, bus_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane placement for stores and lane extraction plus sign/zero extension
// for loads; purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_data,
  output logic [63:0] ld_ext
);

  logic [31:0] shifted;

  always_comb begin
    case (st_size)
      MEM_B:   be = 4'b0001 << st_off;
      MEM_H:   be = 4'b0011 << st_off;
      default: be = 4'hF;
    endcase
    wdata = st_data << {st_off, 3'b000};
  end

  always_comb begin
    shifted = ld_data >> {ld_off, 3'b000};
    case (ld_size)
      MEM_B:   ld_ext = ld_unsigned ? 64'(shifted[7:0])  : {{56{shifted[7]}},  shifted[7:0]};
      MEM_H:   ld_ext = ld_unsigned ? 64'(shifted[15:0]) : {{48{shifted[15]}}, shifted[15:0]};
      MEM_W:   ld_ext = ld_unsigned ? 64'(shifted)       : {{32{shifted[31]}}, shifted};
      default: ld_ext = {32'h0, shifted};
    endcase
  end

endmodule

// File: rtl/lsu_bus_sequencer.sv
// Sequences core loads/stores onto a 32-bit req/ack bus, splitting doublewords
// into two beats and reporting misalignment, bus error and timeout.
module lsu_bus_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_fault,
  output logic              resp_misaligned,
  lsu_bus_sequencer_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state, state_n;
  lsu_req_t          rq;
  logic [31:0]       lo_word;
  logic [CNT_W-1:0]  cnt, cnt_n;

  logic              bus_req_q, bus_req_n, bus_we_q, bus_we_n;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_n;
  logic [31:0]       bus_wdata_q, bus_wdata_n;
  logic [3:0]        bus_be_q, bus_be_n;
  logic              resp_valid_n, resp_fault_n, resp_mis_n;
  logic [63:0]       resp_rdata_n;

  logic              req_aligned, accept, expire;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic [63:0]       ld_ext;

  assign req_aligned = is_aligned(req_size, req_addr[2:0]);
  assign accept      = (state == IDLE) && req_valid && req_aligned;
  assign expire      = !bus.bus_ack && (cnt == CNT_LAST);
  assign busy        = (state == LO) || (state == HI) || accept;

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;

  lsu_lane_align u_align (
    .st_size     (req_size),
    .st_off      (req_addr[1:0]),
    .st_data     (req_wdata[31:0]),
    .be          (st_be),
    .wdata       (st_wdata),
    .ld_size     (rq.size),
    .ld_off      (rq.off),
    .ld_unsigned (rq.uns),
    .ld_data     (bus.bus_rdata),
    .ld_ext      (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (req_valid) state_n = req_aligned ? LO : RESP;
      LO: begin
        if (bus.bus_ack) state_n = (rq.size == MEM_D && !bus.bus_err) ? HI : RESP;
        else if (expire) state_n = RESP;
      end
      HI:      if (bus.bus_ack || expire) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end

  // Next values for the registered bus and response outputs
  always_comb begin
    bus_req_n    = bus_req_q;
    bus_we_n     = bus_we_q;
    bus_addr_n   = bus_addr_q;
    bus_wdata_n  = bus_wdata_q;
    bus_be_n     = bus_be_q;
    resp_valid_n = 1'b0;
    resp_fault_n = 1'b0;
    resp_mis_n   = 1'b0;
    resp_rdata_n = 64'h0;
    cnt_n        = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          bus_req_n   = 1'b1;
          bus_we_n    = req_write;
          bus_addr_n  = {req_addr[ADDR_W-1:2], 2'b00};
          bus_be_n    = st_be;
          bus_wdata_n = st_wdata;
          cnt_n       = '0;
        end else if (req_valid) begin
          resp_valid_n = 1'b1;
          resp_mis_n   = 1'b1;
        end
      end
      LO: begin
        if (bus.bus_ack) begin
          if (rq.size == MEM_D && !bus.bus_err) begin
            bus_addr_n  = bus_addr_q + ADDR_W'(4);
            bus_be_n    = 4'hF;
            bus_wdata_n = rq.wdata_hi;
            cnt_n       = '0;
          end else begin
            bus_req_n    = 1'b0;
            resp_valid_n = 1'b1;
            resp_fault_n = bus.bus_err;
            resp_rdata_n = (bus.bus_err || rq.write) ? 64'h0 : ld_ext;
          end
        end else if (expire) begin
          bus_req_n    = 1'b0;
          resp_valid_n = 1'b1;
          resp_fault_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HI: begin
        if (bus.bus_ack) begin
          bus_req_n    = 1'b0;
          resp_valid_n = 1'b1;
          resp_fault_n = bus.bus_err;
          resp_rdata_n = (bus.bus_err || rq.write) ? 64'h0 : {bus.bus_rdata, lo_word};
        end else if (expire) begin
          bus_req_n    = 1'b0;
          resp_valid_n = 1'b1;
          resp_fault_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_q       <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= 32'h0;
      bus_be_q        <= 4'h0;
      resp_valid      <= 1'b0;
      resp_fault      <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_rdata      <= 64'h0;
      cnt             <= '0;
      rq              <= '0;
      lo_word         <= 32'h0;
    end else begin
      bus_req_q       <= bus_req_n;
      bus_we_q        <= bus_we_n;
      bus_addr_q      <= bus_addr_n;
      bus_wdata_q     <= bus_wdata_n;
      bus_be_q        <= bus_be_n;
      resp_valid      <= resp_valid_n;
      resp_fault      <= resp_fault_n;
      resp_misaligned <= resp_mis_n;
      resp_rdata      <= resp_rdata_n;
      cnt             <= cnt_n;
      if (accept) rq <= '{write: req_write, size: req_size, uns: req_unsigned,
                          off: req_addr[1:0], wdata_hi: req_wdata[63:32]};
      if (state == LO && bus.bus_ack) lo_word <= bus.bus_rdata;
    end
  end

endmodule
